// File: rtl/elevator_car_ctrl_if.sv
// Call inputs and car status outputs of the 4-floor elevator car controller.
// master = call encoder / observer side, slave = car controller.
interface elevator_car_ctrl_if;
  logic [1:0] up_or_down;
  logic [1:0] actual_stage;
  logic [1:0] current_floor;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic [3:0] pending;
  logic       arrive;

  modport master (
    output up_or_down,
    output actual_stage,
    input  current_floor,
    input  moving,
    input  dir_up,
    input  door_open,
    input  pending,
    input  arrive
  );

  modport slave (
    input  up_or_down,
    input  actual_stage,
    output current_floor,
    output moving,
    output dir_up,
    output door_open,
    output pending,
    output arrive
  );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: pending-call mask, SCAN direction choice,
// floor travel timer and door timer sharing one down-counter.
module elevator_car_ctrl #(
  parameter int FLOOR_TICKS = 16,
  parameter int DOOR_TICKS  = 8,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  elevator_car_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVING,
    S_DOOR
  } state_t;

  localparam logic [CNT_W-1:0] FLOOR_LD = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LD  = CNT_W'(DOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           r_state, w_state;
  logic [1:0]       r_floor, w_floor;
  logic             r_dir, w_dir;
  logic [3:0]       r_pend, w_pend;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_arrive, w_arrive;

  logic [3:0] w_req;
  logic [3:0] w_ahead_up;
  logic [3:0] w_ahead_dn;
  logic [1:0] w_next_fl;
  logic       w_unused;

  assign w_unused   = bus.up_or_down[0];
  assign w_req      = bus.up_or_down[1] ?
                      (4'b0001 << bus.actual_stage) : 4'b0000;
  assign w_ahead_up = r_pend & (4'b1110 << r_floor);
  assign w_ahead_dn = r_pend & (4'b0111 >> (2'd3 - r_floor));

  // Clamped neighbour floor in the current direction
  always_comb begin
    w_next_fl = r_floor;
    if (r_dir) begin
      if (r_floor != 2'd3) w_next_fl = r_floor + 2'd1;
    end else begin
      if (r_floor != 2'd0) w_next_fl = r_floor - 2'd1;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_floor  = r_floor;
    w_dir    = r_dir;
    w_pend   = r_pend | w_req;
    w_cnt    = r_cnt;
    w_arrive = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend[r_floor]) begin
          w_state         = S_DOOR;
          w_pend[r_floor] = 1'b0;
          w_cnt           = DOOR_LD;
        end else if (|r_pend) begin
          w_dir   = r_dir ? (|w_ahead_up) : ~(|w_ahead_dn);
          w_state = S_MOVING;
          w_cnt   = FLOOR_LD;
        end
      end
      S_MOVING: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - ONE;
        end else begin
          w_floor  = w_next_fl;
          w_arrive = 1'b1;
          if (r_pend[w_next_fl]) begin
            w_state           = S_DOOR;
            w_pend[w_next_fl] = 1'b0;
            w_cnt             = DOOR_LD;
          end else begin
            w_cnt = FLOOR_LD;
          end
        end
      end
      S_DOOR: begin
        if (w_req[r_floor]) begin
          w_pend[r_floor] = 1'b0;
          w_cnt           = DOOR_LD;
        end else if (r_cnt == '0) begin
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt - ONE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_floor  <= 2'd0;
      r_dir    <= 1'b1;
      r_pend   <= 4'b0000;
      r_cnt    <= '0;
      r_arrive <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_floor  <= w_floor;
      r_dir    <= w_dir;
      r_pend   <= w_pend;
      r_cnt    <= w_cnt;
      r_arrive <= w_arrive;
    end
  end

  assign bus.current_floor = r_floor;
  assign bus.moving        = (r_state == S_MOVING);
  assign bus.dir_up        = r_dir;
  assign bus.door_open     = (r_state == S_DOOR);
  assign bus.pending       = r_pend;
  assign bus.arrive        = r_arrive;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl, FLOOR_TICKS=4, DOOR_TICKS=3.
// Inputs change on the falling edge; outputs are checked there too.
module tb_elevator_car_ctrl;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   n_fail;

  elevator_car_ctrl_if ifc();

  elevator_car_ctrl #(
    .FLOOR_TICKS(4),
    .DOOR_TICKS (3),
    .CNT_W      (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [1:0] f,
                     input logic mv, input logic du, input logic dr,
                     input logic [3:0] p, input logic ar);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {ifc.current_floor, ifc.moving, ifc.dir_up,
           ifc.door_open, ifc.pending, ifc.arrive};
    exp = {f, mv, du, dr, p, ar};
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got fl=%0d mv=%b up=%b door=%b pend=%b arr=%b, want fl=%0d mv=%b up=%b door=%b pend=%b arr=%b",
             tag, obs[9:8], obs[7], obs[6], obs[5], obs[4:1], obs[0],
             f, mv, du, dr, p, ar);
    end
  endtask

  task automatic st(input string tag, input logic [1:0] f,
                    input logic mv, input logic du, input logic dr,
                    input logic [3:0] p, input logic ar);
    step();
    chk(tag, f, mv, du, dr, p, ar);
  endtask

  task automatic stn(input int n, input string tag, input logic [1:0] f,
                     input logic mv, input logic du, input logic dr,
                     input logic [3:0] p, input logic ar);
    for (int i = 0; i < n; i++) st(tag, f, mv, du, dr, p, ar);
  endtask

  task automatic call(input logic [1:0] code, input logic [1:0] fl);
    ifc.up_or_down   = code;
    ifc.actual_stage = fl;
  endtask

  task automatic nocall();
    ifc.up_or_down   = 2'b00;
    ifc.actual_stage = 2'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    chk("reset", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    nocall();

    // reset, then idle with no calls
    do_reset();
    stn(20, "idle", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // single call to floor 2
    call(2'b11, 2'd2);
    st("s1_cap", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0);
    nocall();
    stn(4, "s1_mv0", 2'd0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0);
    st("s1_arr1", 2'd1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1);
    stn(3, "s1_mv1", 2'd1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0);
    st("s1_arr2", 2'd2, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
    stn(2, "s1_door", 2'd2, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    st("s1_idle", 2'd2, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // same-floor call with a door re-open
    do_reset();
    call(2'b10, 2'd0);
    st("s2_cap", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    nocall();
    st("s2_d1", 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    st("s2_d2", 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    call(2'b10, 2'd0);
    st("s2_reopen", 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    nocall();
    stn(2, "s2_d", 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    stn(2, "s2_idle", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // SCAN: call 3, then call 0 while passing floor 1 upward
    call(2'b11, 2'd3);
    st("s3_cap", 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0);
    nocall();
    stn(4, "s3_mv0", 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0);
    st("s3_arr1", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1);
    call(2'b10, 2'd0);
    st("s3_cap0", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0);
    nocall();
    stn(2, "s3_mv1", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0);
    st("s3_arr2", 2'd2, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b1);
    stn(3, "s3_mv2", 2'd2, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0);
    st("s3_arr3", 2'd3, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
    stn(2, "s3_door3", 2'd3, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    st("s3_idle3", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    stn(4, "s3_rev", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    st("s3_dn2", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    stn(3, "s3_mvd2", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    st("s3_dn1", 2'd1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    stn(3, "s3_mvd1", 2'd1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    st("s3_dn0", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    stn(2, "s3_door0", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    st("s3_idle0", 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // pick-up en route: direction flips up from floor 0
    call(2'b11, 2'd3);
    st("s4_cap", 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    nocall();
    stn(4, "s4_mv0", 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0);
    st("s4_arr1", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1);
    st("s4_mv1", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0);
    call(2'b10, 2'd2);
    st("s4_cap2", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1100, 1'b0);
    nocall();
    st("s4_mv1b", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1100, 1'b0);
    st("s4_arr2", 2'd2, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1);
    stn(2, "s4_door2", 2'd2, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0);
    st("s4_idle2", 2'd2, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0);
    stn(4, "s4_mv2", 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0);
    st("s4_arr3", 2'd3, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
    stn(2, "s4_door3", 2'd3, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    st("s4_idle3", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

    // reset mid-move with a call arriving in the reset cycle
    call(2'b10, 2'd0);
    st("s5_cap", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    nocall();
    st("s5_mv", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    st("s5_mv_c2", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0);
    rst_n = 1'b0;
    call(2'b11, 2'd1);
    st("s5_rst", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    nocall();
    stn(6, "s5_idle", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
